// File: rtl/bsm_sequencer_if.sv
// Bus bundle between the beta-recursion sequencer, the branch-metric RAM,
// the backward ACS unit and the beta memory.
interface bsm_sequencer_if #(
    parameter int unsigned W      = 12,
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] blk_len;
    logic              busy;
    logic              done;
    logic              bm_rd;
    logic [ADDR_W-1:0] bm_addr;
    logic [8*W-1:0]    sm_out;
    logic [8*W-1:0]    sm_in;
    logic              bw_en;
    logic [ADDR_W-1:0] bw_addr;
    logic [8*W-1:0]    bw_data;
    logic              bw_ready;

    modport master (
        input  start, blk_len, sm_in, bw_ready,
        output busy, done, bm_rd, bm_addr, sm_out, bw_en, bw_addr, bw_data
    );

    modport slave (
        output start, blk_len, sm_in, bw_ready,
        input  busy, done, bm_rd, bm_addr, sm_out, bw_en, bw_addr, bw_data
    );
endinterface

// File: rtl/bsm_sequencer.sv
// Backward state-metric (beta) recursion controller for the 8-state MAP decoder:
// owns the beta register, normalises ACS results and streams betas k = N..0 out.
module bsm_sequencer #(
    parameter int unsigned W        = 12,
    parameter int unsigned ADDR_W   = 10,
    parameter int          INIT_NEG = -512
) (
    input logic            clock,
    input logic            reset,
    bsm_sequencer_if.master bus
);
    localparam int unsigned NS = 8;
    localparam int unsigned VW = NS * W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        CALC  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] k;
    logic [VW-1:0]     sm_reg;
    logic              busy;
    logic              done;
    logic              bm_rd;
    logic [ADDR_W-1:0] bm_addr;
    logic              bw_en;
    logic [ADDR_W-1:0] bw_addr;
    logic [VW-1:0]     bw_data;

    logic [VW-1:0]     init_vec;
    logic [VW-1:0]     norm_vec;

    // Terminated-trellis start vector and state-0-relative normalisation of the ACS results
    always_comb begin
        init_vec = '0;
        norm_vec = '0;
        for (int s = 0; s < NS; s++) begin
            init_vec[W*s +: W] = (s == 0) ? W'(0) : W'(INIT_NEG);
            norm_vec[W*s +: W] = bus.sm_in[W*s +: W] - bus.sm_in[W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            sm_reg  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bm_rd   <= 1'b0;
            bm_addr <= '0;
            bw_en   <= 1'b0;
            bw_addr <= '0;
            bw_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        k     <= bus.blk_len;
                        busy  <= 1'b1;
                        state <= INIT;
                    end
                end
                INIT: begin
                    sm_reg  <= init_vec;
                    bw_en   <= 1'b1;
                    bw_addr <= k;
                    bw_data <= init_vec;
                    state   <= WRITE;
                end
                WRITE: begin
                    // Request held stable until the beta memory accepts it
                    if (bus.bw_ready) begin
                        bw_en <= 1'b0;
                        if (k == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            k       <= k - ADDR_W'(1);
                            bm_rd   <= 1'b1;
                            bm_addr <= k - ADDR_W'(1);
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    bm_rd <= 1'b0;
                    state <= CALC;
                end
                CALC: begin
                    sm_reg  <= norm_vec;
                    bw_en   <= 1'b1;
                    bw_addr <= k;
                    bw_data <= norm_vec;
                    state   <= WRITE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sm_out  = sm_reg;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.bm_rd   = bm_rd;
    assign bus.bm_addr = bm_addr;
    assign bus.bw_en   = bw_en;
    assign bus.bw_addr = bw_addr;
    assign bus.bw_data = bw_data;

endmodule
